// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer.
// One full-adder slice is evaluated per clock from LSB to MSB. The running
// carry is held in a flip-flop, so a WIDTH-bit operation takes WIDTH cycles.
// The start/busy/done handshake and the sum/cout/ovf results are all registered.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Bit counter only has to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CW-1:0]    count;

  logic             slice_s;
  logic             slice_co;

  // The shared full-adder slice always works on the current LSBs.
  assign slice_s  = a_sr[0] ^ b_sr[0] ^ carry;
  assign slice_co = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // Sequencer: the state, the datapath shift registers and the registered
  // outputs are all updated together.
  // NOTE: non-blocking assignments, so every register here sees the values
  // from before the edge. For example, ovf reads the old carry, which is the
  // carry into the MSB, and not the carry being written on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            a_sr  <= a;
            // Subtract is computed as a + ~b + 1, so the add path is reused.
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            count <= '0;
            psum  <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          psum  <= {slice_s, psum[WIDTH-1:1]};
          carry <= slice_co;
          count <= count + 1'b1;
          if (count == LAST) begin
            state <= DONE;
            done  <= 1'b1;
            sum   <= {slice_s, psum[WIDTH-1:1]};
            cout  <= slice_co;
            // Overflow occurs when the carry into the MSB differs from the carry out of it.
            ovf   <= carry ^ slice_co;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
